fp_mant_add_norm: RTL and testbench

FP_MANT_ADD_NORM -- requirements
Module: fp_mant_add_norm

---
 rtl/fp_mant_add_norm.sv | 153 +++++++++++++++
 tb/tb_fp_mant_add_norm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mant_add_norm.sv
`default_nettype none
// ============================================================================
// Module   : fp_mant_add_norm
// Brief    : Sequential mantissa add/subtract and normalise for a 1-3-4 float.
// Revision : 1.0  initial release
// ============================================================================
module fp_mant_add_norm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] big_mant,
    input  logic [5:0] small_mant,
    input  logic [2:0] big_exp,
    input  logic       big_sign,
    input  logic       small_sign,
    output logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic       uf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] big_q, big_d;
    logic [5:0] small_q, small_d;
    logic       big_sign_q, big_sign_d;
    logic       small_sign_q, small_sign_d;
    logic [5:0] mant_q, mant_d;
    logic [2:0] exp_q, exp_d;
    logic       sign_q, sign_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;
    logic       uf_q, uf_d;

    logic       eff_sub;
    logic [6:0] sum;

    always_comb begin
        state_d      = state_q;
        big_d        = big_q;
        small_d      = small_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        mant_d       = mant_q;
        exp_d        = exp_q;
        sign_d       = sign_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        uf_d         = uf_q;

        eff_sub = big_sign_q ^ small_sign_q;
        sum     = eff_sub ? ({1'b0, big_q} - {1'b0, small_q})
                          : ({1'b0, big_q} + {1'b0, small_q});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    big_d        = big_mant;
                    small_d      = small_mant;
                    big_sign_d   = big_sign;
                    small_sign_d = small_sign;
                    exp_d        = big_exp;
                    ovf_d        = 1'b0;
                    uf_d         = 1'b0;
                    state_d      = S_ADD;
                end
            end
            S_ADD: begin
                // Magnitude never exceeds 62, so negating the low six bits is exact.
                if (sum[6]) begin
                    mant_d = 6'd0 - sum[5:0];
                    sign_d = ~big_sign_q;
                end else begin
                    mant_d = sum[5:0];
                    sign_d = big_sign_q;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (mant_q == 6'd0) begin
                    result_d = 8'h00;
                    state_d  = S_DONE;
                end else if (mant_q[5] && (exp_q == 3'd7)) begin
                    result_d = {sign_q, 3'b111, 4'b1111};
                    ovf_d    = 1'b1;
                    state_d  = S_DONE;
                end else if (mant_q[5]) begin
                    result_d = {sign_q, exp_q + 3'd1, mant_q[4:1]};
                    state_d  = S_DONE;
                end else if (mant_q[4]) begin
                    result_d = {sign_q, exp_q, mant_q[3:0]};
                    state_d  = S_DONE;
                end else if (exp_q == 3'd0) begin
                    result_d = 8'h00;
                    uf_d     = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    mant_d = {mant_q[4:0], 1'b0};
                    exp_d  = exp_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            big_q        <= 6'd0;
            small_q      <= 6'd0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            mant_q       <= 6'd0;
            exp_q        <= 3'd0;
            sign_q       <= 1'b0;
            result_q     <= 8'h00;
            ovf_q        <= 1'b0;
            uf_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            big_q        <= big_d;
            small_q      <= small_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            mant_q       <= mant_d;
            exp_q        <= exp_d;
            sign_q       <= sign_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            uf_q         <= uf_d;
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;
    assign uf     = uf_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fp_mant_add_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mant_add_norm
// Brief    : Self-checking bench for fp_mant_add_norm against a value-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_mant_add_norm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] big_mant;
    logic [5:0] small_mant;
    logic [2:0] big_exp;
    logic       big_sign;
    logic       small_sign;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       uf;

    int checks = 0;
    int errors = 0;

    fp_mant_add_norm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .big_mant   (big_mant),
        .small_mant (small_mant),
        .big_exp    (big_exp),
        .big_sign   (big_sign),
        .small_sign (small_sign),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .uf         (uf)
    );

    always #5 clk = ~clk;

    // Reference: signed integer sum, then place the leading one at bit 4.
    function automatic void model(input logic [5:0] bm, input logic [5:0] sm,
                                  input logic [2:0] be, input logic bs, input logic ss,
                                  output logic [7:0] res, output logic o, output logic u,
                                  output int k);
        int   s;
        int   p;
        int   sh;
        logic sg;
        logic [2:0] ee;
        logic [3:0] mm;
        s  = (bs ^ ss) ? (int'(bm) - int'(sm)) : (int'(bm) + int'(sm));
        sg = bs;
        if (s < 0) begin
            s  = -s;
            sg = ~bs;
        end
        o = 1'b0; u = 1'b0; k = 0; res = 8'h00;
        if (s == 0) begin
            res = 8'h00;
        end else if (s >= 32) begin
            if (be == 3'd7) begin
                res = {sg, 7'h7F};
                o   = 1'b1;
            end else begin
                ee  = be + 3'd1;
                mm  = 4'((s / 2) % 16);
                res = {sg, ee, mm};
            end
        end else begin
            p = 0;
            for (int i = 0; i < 5; i++) if (((s >> i) & 1) == 1) p = i;
            sh = 4 - p;
            if (sh > int'(be)) begin
                u = 1'b1;
                k = int'(be);
            end else begin
                ee  = be - 3'(sh);
                mm  = 4'((s << sh) % 16);
                res = {sg, ee, mm};
                k   = sh;
            end
        end
    endfunction

    // Drives one operation; returns the observed outputs at done and its latency.
    task automatic run_op(input logic [5:0] bm, input logic [5:0] sm, input logic [2:0] be,
                          input logic bs, input logic ss, input bit hold,
                          output logic [7:0] res, output logic o, output logic u,
                          output int lat, output int proto_err);
        lat = -1;
        proto_err = 0;
        @(negedge clk);
        big_mant = bm; small_mant = sm; big_exp = be; big_sign = bs; small_sign = ss;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                if (busy) proto_err++;
            end else if (!busy) begin
                proto_err++;
            end
        end
        res = result; o = ovf; u = uf;
        @(posedge clk); #1;
        start = 1'b0;
        if (done || busy) proto_err++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0;
        big_mant = '0; small_mant = '0; big_exp = '0; big_sign = 1'b0; small_sign = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (uf !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", uf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [5:0] tb_bm [6] = '{6'b011000, 6'b011000, 6'b010100, 6'b010000, 6'b011111, 6'b010001};
        logic [5:0] tb_sm [6] = '{6'b010000, 6'b010000, 6'b010100, 6'b011000, 6'b011111, 6'b010000};
        logic [2:0] tb_be [6] = '{3'd3, 3'd3, 3'd5, 3'd3, 3'd7, 3'd1};
        logic       tb_bs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       tb_ss [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] ex_r  [6] = '{8'h44, 8'h20, 8'h00, 8'hA0, 8'h7F, 8'h00};
        logic       ex_o  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       ex_u  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int         ex_l  [6] = '{2, 3, 2, 3, 2, 3};
        logic [7:0] r;
        logic       o, u;
        int         lat, pe;
        for (int i = 0; i < 6; i++) begin
            run_op(tb_bm[i], tb_sm[i], tb_be[i], tb_bs[i], tb_ss[i], 1'b0, r, o, u, lat, pe);
            checks++; if (r !== ex_r[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, ex_r[i]); end
            checks++; if (o !== ex_o[i]) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, o, ex_o[i]); end
            checks++; if (u !== ex_u[i]) begin errors++; $display("FAIL dir%0d_uf got=%b exp=%b", i, u, ex_u[i]); end
            checks++; if (lat != ex_l[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, ex_l[i]); end
            checks++; if (pe != 0) begin errors++; $display("FAIL dir%0d_protocol got=%0d exp=0", i, pe); end
        end
    endtask

    task automatic test_random;
        logic [5:0] bm, sm;
        logic [2:0] be;
        logic       bs, ss;
        logic [7:0] r, er;
        logic       o, u, eo, eu;
        int         lat, pe, k;
        for (int n = 0; n < 150; n++) begin
            bm = {2'b01, 4'($urandom_range(0, 15))};
            sm = 6'($urandom_range(0, 31));
            be = 3'($urandom_range(0, 7));
            bs = 1'($urandom_range(0, 1));
            ss = 1'($urandom_range(0, 1));
            model(bm, sm, be, bs, ss, er, eo, eu, k);
            run_op(bm, sm, be, bs, ss, 1'b0, r, o, u, lat, pe);
            checks++;
            if ({r, o, u} !== {er, eo, eu} || lat != 2 + k || pe != 0) begin
                errors++;
                $display("FAIL rand%0d bm=%b sm=%b be=%0d bs=%b ss=%b got r=%h o=%b u=%b lat=%0d pe=%0d exp r=%h o=%b u=%b lat=%0d",
                         n, bm, sm, be, bs, ss, r, o, u, lat, pe, er, eo, eu, 2 + k);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] r;
        logic       o, u;
        int         lat, pe;
        run_op(6'b011111, 6'b011111, 3'd7, 1'b0, 1'b0, 1'b0, r, o, u, lat, pe);
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL b2b_ovf_set got=%b exp=1", o); end
        run_op(6'b011000, 6'b010000, 3'd3, 1'b0, 1'b0, 1'b1, r, o, u, lat, pe);
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear got=%b exp=0", o); end
        checks++; if (r !== 8'h44) begin errors++; $display("FAIL b2b_result got=%h exp=44", r); end
        checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        checks++; if (pe != 0) begin errors++; $display("FAIL b2b_protocol got=%0d exp=0", pe); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done || busy || result !== 8'h44) begin
                errors++;
                $display("FAIL b2b_idle%0d got done=%b busy=%b r=%h exp done=0 busy=0 r=44", c, done, busy, result);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] r, er;
        logic       o, u, eo, eu;
        int         lat, pe, k, dones;
        run_op(6'b011111, 6'b011111, 3'd7, 1'b1, 1'b1, 1'b0, r, o, u, lat, pe);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL rmid_pre_result got=%h exp=ff", r); end
        @(negedge clk);
        big_mant = 6'b010001; small_mant = 6'b010000; big_exp = 3'd7; big_sign = 1'b0; small_sign = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_in_norm busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 8'h00 || busy || done || ovf || uf) begin
            errors++;
            $display("FAIL rmid_async got r=%h b=%b d=%b o=%b u=%b exp all zero", result, busy, done, ovf, uf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", dones); end
        model(6'b010001, 6'b010000, 3'd7, 1'b0, 1'b1, er, eo, eu, k);
        run_op(6'b010001, 6'b010000, 3'd7, 1'b0, 1'b1, 1'b0, r, o, u, lat, pe);
        checks++;
        if ({r, o, u} !== {er, eo, eu} || lat != 2 + k || pe != 0) begin
            errors++;
            $display("FAIL rmid_after got r=%h o=%b u=%b lat=%0d pe=%0d exp r=%h o=%b u=%b lat=%0d",
                     r, o, u, lat, pe, er, eo, eu, 2 + k);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
